// File: rtl/adpll_regbank_mc.sv
// Multi-channel CPU register bank for ADPLL control cores.
// Each channel page holds shadow/active configuration with atomic commit,
// a timed soft-reset pulse, sticky lock/saturation status with W1C,
// a saturating lock-loss counter and a per-channel interrupt enable.
//
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   valid/address/wdata/wstrb   CPU request (held until ready)
//   rdata/ready     registered read data and single-cycle acknowledge
//   ch_lock/ch_sat  per-channel status flags (synchronous to clk)
//   fcw_o/mode_o/en_o/gains_o   active per-channel configuration
//   ch_rst_o        per-channel soft-reset pulse
//   irq             interrupt request
module adpll_regbank_mc #(
    parameter int unsigned N_CH          = 4,
    parameter int unsigned ADDR_W        = 8,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned FCW_W         = 26,
    parameter logic [FCW_W-1:0] FCW_RST  = 26'h2620000,
    parameter int unsigned RST_PULSE_CYC = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid,
    input  logic [ADDR_W-1:0]       address,
    input  logic [DATA_W-1:0]       wdata,
    input  logic                    wstrb,
    output logic [DATA_W-1:0]       rdata,
    output logic                    ready,
    input  logic [N_CH-1:0]         ch_lock,
    input  logic [N_CH-1:0]         ch_sat,
    output logic [N_CH*FCW_W-1:0]   fcw_o,
    output logic [N_CH*2-1:0]       mode_o,
    output logic [N_CH-1:0]         en_o,
    output logic [N_CH*16-1:0]      gains_o,
    output logic [N_CH-1:0]         ch_rst_o,
    output logic                    irq
);

    localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned CHF_W = ADDR_W - 4;
    localparam int unsigned PC_W  = (RST_PULSE_CYC > 1) ? $clog2(RST_PULSE_CYC) : 1;
    localparam logic [15:0] GAINS_RST = 16'hE870;

    // Per-channel state
    logic [FCW_W-1:0] fcw_sh   [N_CH];
    logic [FCW_W-1:0] fcw_act  [N_CH];
    logic [1:0]       mode_sh  [N_CH];
    logic [1:0]       mode_act [N_CH];
    logic [15:0]      gains_sh [N_CH];
    logic [15:0]      gains_act[N_CH];
    logic [PC_W-1:0]  pulse_rem[N_CH];
    logic [CNT_W-1:0] loss_cnt [N_CH];
    logic [N_CH-1:0]  en_sh, en_act, pending;
    logic [N_CH-1:0]  lock_q, lock_qd, sat_q, sat_qd;
    logic [N_CH-1:0]  lock_lost, sat_hit, irq_en_lock, irq_en_sat;

    // Request decode
    logic             acc, wr_acc, ch_ok;
    logic [3:0]       off;
    logic [CHF_W-1:0] ch_full;
    logic [CH_W-1:0]  ch;
    logic [DATA_W-1:0] rd_val;

    assign acc     = valid & ~ready;
    assign wr_acc  = acc & wstrb;
    assign off     = address[3:0];
    assign ch_full = address[ADDR_W-1:4];
    assign ch      = ch_full[CH_W-1:0];
    assign ch_ok   = (32'(ch_full) < 32'(N_CH));

    // Registered-input edge detectors
    logic [N_CH-1:0] lock_fall, sat_rise;
    assign lock_fall = lock_qd & ~lock_q;
    assign sat_rise  = sat_q & ~sat_qd;

    // Per-channel write strobes
    logic [N_CH-1:0] wr_fcw, wr_mode, wr_gains, do_commit, pulse_ld;
    logic [N_CH-1:0] clr_lost, clr_hit, clr_cnt, wr_irqen;

    always_comb begin
        wr_fcw    = '0;
        wr_mode   = '0;
        wr_gains  = '0;
        do_commit = '0;
        pulse_ld  = '0;
        clr_lost  = '0;
        clr_hit   = '0;
        clr_cnt   = '0;
        wr_irqen  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (wr_acc && ch_ok && (ch == CH_W'(i))) begin
                case (off)
                    4'd0: wr_fcw[i]    = 1'b1;
                    4'd1: wr_mode[i]   = 1'b1;
                    4'd2: wr_gains[i]  = 1'b1;
                    4'd3: do_commit[i] = 1'b1;
                    4'd4: pulse_ld[i]  = wdata[0];
                    4'd5: begin
                        clr_lost[i] = wdata[2];
                        clr_hit[i]  = wdata[3];
                    end
                    4'd6: clr_cnt[i]   = 1'b1;
                    4'd7: wr_irqen[i]  = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Read mux; out-of-range pages read all ones
    always_comb begin
        rd_val = '0;
        if (!ch_ok) begin
            rd_val = '1;
        end else begin
            case (off)
                4'd0: rd_val[FCW_W-1:0] = fcw_sh[ch];
                4'd1: rd_val[2:0]       = {en_sh[ch], mode_sh[ch]};
                4'd2: rd_val[15:0]      = gains_sh[ch];
                4'd3: rd_val[0]         = pending[ch];
                4'd4: rd_val[0]         = ch_rst_o[ch];
                4'd5: rd_val[3:0]       = {sat_hit[ch], lock_lost[ch], sat_q[ch], lock_q[ch]};
                4'd6: rd_val[CNT_W-1:0] = loss_cnt[ch];
                4'd7: rd_val[1:0]       = {irq_en_sat[ch], irq_en_lock[ch]};
                default: ;
            endcase
        end
    end

    // Bus handshake, input capture and interrupt
    always_ff @(posedge clk) begin
        if (!rst) begin
            ready   <= 1'b0;
            rdata   <= '0;
            irq     <= 1'b0;
            lock_q  <= '0;
            lock_qd <= '0;
            sat_q   <= '0;
            sat_qd  <= '0;
        end else begin
            ready   <= acc;
            rdata   <= acc ? rd_val : '0;
            irq     <= |((lock_lost & irq_en_lock) | (sat_hit & irq_en_sat));
            lock_q  <= ch_lock;
            lock_qd <= lock_q;
            sat_q   <= ch_sat;
            sat_qd  <= sat_q;
        end
    end

    // Channel pages
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_CH; i++) begin
                fcw_sh[i]    <= FCW_RST;
                fcw_act[i]   <= FCW_RST;
                mode_sh[i]   <= 2'b00;
                mode_act[i]  <= 2'b00;
                gains_sh[i]  <= GAINS_RST;
                gains_act[i] <= GAINS_RST;
                pulse_rem[i] <= '0;
                loss_cnt[i]  <= '0;
            end
            en_sh       <= '0;
            en_act      <= '0;
            pending     <= '0;
            lock_lost   <= '0;
            sat_hit     <= '0;
            irq_en_lock <= '0;
            irq_en_sat  <= '0;
            ch_rst_o    <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (wr_fcw[i]) begin
                    fcw_sh[i]  <= wdata[FCW_W-1:0];
                    pending[i] <= 1'b1;
                end
                if (wr_mode[i]) begin
                    mode_sh[i] <= wdata[1:0];
                    en_sh[i]   <= wdata[2];
                    pending[i] <= 1'b1;
                end
                if (wr_gains[i]) begin
                    gains_sh[i] <= wdata[15:0];
                    pending[i]  <= 1'b1;
                end
                if (do_commit[i]) begin
                    fcw_act[i]   <= fcw_sh[i];
                    mode_act[i]  <= mode_sh[i];
                    en_act[i]    <= en_sh[i];
                    gains_act[i] <= gains_sh[i];
                    pending[i]   <= 1'b0;
                end
                if (wr_irqen[i]) begin
                    irq_en_lock[i] <= wdata[0];
                    irq_en_sat[i]  <= wdata[1];
                end

                // Pulse is high for the load cycle plus RST_PULSE_CYC-1 more
                if (pulse_ld[i]) begin
                    ch_rst_o[i]  <= 1'b1;
                    pulse_rem[i] <= PC_W'(RST_PULSE_CYC - 1);
                end else if (pulse_rem[i] != '0) begin
                    pulse_rem[i] <= pulse_rem[i] - PC_W'(1);
                end else begin
                    ch_rst_o[i]  <= 1'b0;
                end

                // Events win over a simultaneous clear
                lock_lost[i] <= (lock_lost[i] & ~clr_lost[i]) | lock_fall[i];
                sat_hit[i]   <= (sat_hit[i] & ~clr_hit[i]) | sat_rise[i];

                if (clr_cnt[i]) begin
                    loss_cnt[i] <= lock_fall[i] ? CNT_W'(1) : '0;
                end else if (lock_fall[i] && (loss_cnt[i] != '1)) begin
                    loss_cnt[i] <= loss_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Pack active configuration onto the output buses
    for (genvar g = 0; g < N_CH; g++) begin : g_out
        assign fcw_o[g*FCW_W +: FCW_W] = fcw_act[g];
        assign mode_o[g*2 +: 2]        = mode_act[g];
        assign gains_o[g*16 +: 16]     = gains_act[g];
    end
    assign en_o = en_act;

    logic unused_wdata;
    assign unused_wdata = ^wdata;

endmodule

// File: doc/adpll_regbank_mc.md
# adpll_regbank_mc

Parametrised multi-channel CPU register bank for ADPLL cores. It replaces the single-channel control register set with N_CH independent channel pages. Each page has shadow/active configuration with atomic commit, timed soft-reset pulses, sticky lock/saturation status with write-1-to-clear, lock-loss counters and a maskable interrupt. It sits between the CPU bus and N_CH ADPLL control cores.

## Interface
- N_CH, 4: number of ADPLL channels (1..16); CH_W = max(1, clog2(N_CH))
- ADDR_W, 8: address width; must be ≥ 4 + CH_W
- DATA_W, 32: CPU data width
- FCW_W, 26: FCW width; must be ≤ DATA_W
- FCW_RST, 26'h2620000: FCW reset value (2440 MHz)
- RST_PULSE_CYC, 4: soft-reset pulse length in cycles (≥ 1)
- CNT_W, 8: lock-loss counter width
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset (asserted when 0)
- valid  in  1  CPU request; held until ready
- address  in  ADDR_W  [3:0] register offset, [ADDR_W-1:4] channel index
- wdata  in  DATA_W  write data
- wstrb  in  1  1 = write, 0 = read
- rdata  out  DATA_W  read data, valid while ready = 1
- ready  out  1  single-cycle acknowledge
- ch_lock  in  N_CH  per-channel lock flag, synchronous to clk
- ch_sat  in  N_CH  per-channel saturation flag, synchronous to clk
- fcw_o  out  N_CH*FCW_W  active FCW; channel i at slice i
- mode_o  out  N_CH*2  active adpll mode
- en_o  out  N_CH  active enable
- gains_o  out  N_CH*16  active gains, packed {alpha_l, alpha_m, alpha_s, beta}, 4 bits each
- ch_rst_o  out  N_CH  per-channel soft-reset pulse, active high
- irq  out  1  interrupt request

## Operation
- Transaction acceptance: a request is accepted at any rising edge where valid = 1 and ready = 0. The next cycle has ready = 1 for exactly one cycle, with rdata registered. The host holds valid until it sees ready.
- Page decode: channel index ≥ N_CH means the write is ignored and the read returns all ones. Unlisted offsets: writes ignored, reads return 0. Unused read bits are 0.
- Offset 0, FCW_SH (RW): shadow FCW = wdata[FCW_W-1:0]; sets pending.
- Offset 1, MODE_SH (RW): bits [1:0] are mode and bit 2 is en; sets pending.
- Offset 2, GAINS_SH (RW): bits [15:0]; sets pending.
- Offset 3, COMMIT:
  - Write (any data): copies all three shadows to the active outputs at the acceptance edge and clears pending.
  - Read: bit0 = pending.
- Offset 4, SOFT_RST: a write with wdata[0] = 1 loads the channel pulse counter. ch_rst_o[i] is then high for exactly RST_PULSE_CYC cycles. A rewrite during a pulse restarts the full length. wdata[0] = 0 has no effect. Reads return bit0 = pulse active.
- Offset 5, STATUS:
  - Read: bit0 = live lock, bit1 = live sat, bit2 = lock_lost sticky, bit3 = sat_hit sticky.
  - Write: 1 in bit 2 or bit 3 clears that sticky bit.
- Offset 6, LOSS_CNT:
  - Read: the CNT_W-bit count of lock 1→0 transitions, saturating at all ones.
  - Write (any data): clears the count.
- Offset 7, IRQ_EN (RW): bit0 enables lock-loss, bit1 enables sat.
- Event detection: ch_lock and ch_sat are registered once per channel. A lock falling edge sets lock_lost and increments the count. A sat rising edge sets sat_hit.
- Simultaneous events:
  - Event and W1C in the same cycle: the sticky bit ends set.
  - Lock loss and count clear in the same cycle: count = 1.
- irq: registered OR over channels of (lock_lost & en0) | (sat_hit & en1).
- Commit does not affect the soft-reset pulse; a soft reset does not alter any register.

## Timing
- Latency:
  - Write effect (shadow, active, sticky clear, pulse load) happens at the acceptance edge.
  - ready and rdata follow one cycle after acceptance.
  - ch_rst_o rises in the cycle after the acceptance edge.
- irq is asserted one cycle after the sticky bit sets. Sticky bits set one cycle after the input edge is sampled, because of the input register.
- Reset values:
  - Outputs: ready = 0, rdata = 0, irq = 0, ch_rst_o = 0.
  - Active and shadow state: fcw = FCW_RST, mode = 0, en = 0, gains = 16'hE870.
  - Other state: pending = 0, sticky = 0, counts = 0, IRQ_EN = 0, input registers = 0.
  - A lock input already low at reset release is not a loss.
- Reset mid-operation: rst = 0 dominates every register in that cycle. An in-flight transaction is dropped without a ready, and an active pulse is cut.

## Test plan
- Reset, then read every offset of ch0 -> FCW_SH = 0x2620000, GAINS_SH = 0xE870, STATUS = 0, COMMIT = 0; each read gives a single-cycle ready.
- Write FCW_SH ch2 = 0x2700000 -> fcw_o[2] unchanged and COMMIT read = 1. Write COMMIT ch2 -> fcw_o[2] = 0x2700000 one edge later and pending = 0; other channels unchanged.
- SOFT_RST ch1 with RST_PULSE_CYC = 4 -> ch_rst_o[1] high for exactly 4 cycles. Rewrite at pulse cycle 2 -> 4 further cycles, 6 in total.
- IRQ_EN ch3 = 1, toggle ch_lock[3] 1→0 three times -> LOSS_CNT = 3, STATUS bit2 = 1, irq = 1. W1C on bit 2 in the same cycle as a 4th loss -> bit2 stays 1 and count = 4.
- 300 lock losses with CNT_W = 8 -> count holds at 255. A write to LOSS_CNT -> 0.
- Access to channel index N_CH -> read = all ones, write has no effect. Assert rst = 0 mid-pulse and mid-transaction -> all outputs at reset values the next cycle and no ready.
